// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - bit-serial adder, one full-adder cell, LSB-first, WIDTH cycles per add
//
// Purpose:
//   Adds two WIDTH-bit unsigned operands plus a carry-in using a single
//   full-adder cell. The operands are shifted through the cell LSB-first. The
//   carry is fed back through a flop, and the sum bits are collected in a
//   shift register. An add takes WIDTH+2 cycles, from accepting START to
//   being ready in IDLE again.
//
// Optional feature (macro BIT_SERIAL_ADDER_SUB_EN):
//   When defined, a SUB input is added. With SUB=1, ~B is loaded and the
//   carry starts at 1, so SUM = A-B mod 2^WIDTH. In that case COUT=1 means
//   A>=B (no borrow). When the macro is undefined, neither the SUB port nor
//   the inversion logic exists.
//
// Ports:
//   CLK    in   rising-edge clock
//   R      in   asynchronous active-low reset
//   START  in   begin an add; only sampled in IDLE
//   A, B   in   WIDTH-bit operands, captured on the accepted START edge
//   CIN    in   carry-in, captured on the accepted START edge
//   SUB    in   (BIT_SERIAL_ADDER_SUB_EN only) subtract select, captured with operands
//   BUSY   out  high in RUN and DONE
//   DONE   out  one-cycle pulse; SUM/COUT valid
//   SUM    out  WIDTH-bit result, held until the next result completes
//   COUT   out  final carry, held with SUM
//   SER_S  out  sum bit produced this cycle while in RUN, else 0

module bit_serial_adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (b_i & c_i) | (c_i & a_i);
endmodule

module bit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
`ifdef BIT_SERIAL_ADDER_SUB_EN
  input  logic             SUB,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             SER_S
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   areg_q, areg_d;
  logic [WIDTH-1:0]   breg_q, breg_d;
  // Holds the WIDTH-1 sum bits collected so far. The final bit comes
  // straight from the adder on the last RUN edge.
  logic [WIDTH-2:0]   sreg_q, sreg_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic               fa_s;
  logic               fa_c;
  logic [WIDTH-1:0]   b_load;
  logic               c_load;

`ifdef BIT_SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: A + ~B + 1. The carry-in is ignored here.
  assign b_load = SUB ? ~B : B;
  assign c_load = SUB ? 1'b1 : CIN;
`else
  assign b_load = B;
  assign c_load = CIN;
`endif

  bit_serial_adder_fa u_fa (
    .a_i (areg_q[0]),
    .b_i (breg_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  always_comb begin
    state_d = state_q;
    areg_d  = areg_q;
    breg_d  = breg_q;
    sreg_d  = sreg_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    SER_S   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          areg_d  = A;
          breg_d  = b_load;
          carry_d = c_load;
          cnt_d   = '0;
          sreg_d  = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        BUSY    = 1'b1;
        SER_S   = fa_s;
        sreg_d  = {fa_s, sreg_q[WIDTH-2:1]};
        carry_d = fa_c;
        areg_d  = areg_q >> 1;
        breg_d  = breg_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          sum_d   = {fa_s, sreg_q};
          cout_d  = fa_c;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        BUSY    = 1'b1;
        DONE    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state_q <= ST_IDLE;
      areg_q  <= '0;
      breg_q  <= '0;
      sreg_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      areg_q  <= areg_d;
      breg_q  <= breg_d;
      sreg_q  <= sreg_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign SUM  = sum_q;
  assign COUT = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// tb/tb_bit_serial_adder.sv - self-checking bench for bit_serial_adder
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         R = 1'b0;
  logic         START = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         CIN = 1'b0;
`ifdef BIT_SERIAL_ADDER_SUB_EN
  logic         SUB = 1'b0;
`endif
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] SUM;
  logic         COUT;
  logic         SER_S;

  int n_checks = 0;
  int n_errors = 0;

  bit_serial_adder #(.WIDTH(W), .CNT_W(6)) dut (
    .CLK   (CLK),
    .R     (R),
    .START (START),
    .A     (A),
    .B     (B),
    .CIN   (CIN),
`ifdef BIT_SERIAL_ADDER_SUB_EN
    .SUB   (SUB),
`endif
    .BUSY  (BUSY),
    .DONE  (DONE),
    .SUM   (SUM),
    .COUT  (COUT),
    .SER_S (SER_S)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: phase -1 means idle. Phases 0..W-1 are the W bit
  // cycles, and phase W is the single DONE cycle. The result comes from
  // plain integer arithmetic.
  int           phase = -1;
  logic [W:0]   cur = '0;
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;

  always @(posedge CLK or negedge R) begin
    if (!R) begin
      phase     = -1;
      cur       = '0;
      last_sum  = '0;
      last_cout = 1'b0;
    end else if (phase < 0) begin
      if (START) begin
        phase = 0;
`ifdef BIT_SERIAL_ADDER_SUB_EN
        if (SUB)
          cur = {1'b0, A} + {1'b0, ~B} + (W+1)'(1);
        else
`endif
          cur = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, CIN};
      end
    end else if (phase < W) begin
      phase = phase + 1;
      if (phase == W) begin
        last_sum  = cur[W-1:0];
        last_cout = cur[W];
      end
    end else begin
      phase = -1;
    end
  end

  always @(negedge CLK) begin
    check("busy", 32'(BUSY), 32'(phase >= 0));
    check("done", 32'(DONE), 32'(phase == W));
    check("ser_s", 32'(SER_S), (phase >= 0 && phase < W) ? 32'(cur[phase]) : 32'd0);
    if (phase < 0 || phase == W) begin
      check("sum_hold", 32'(SUM), 32'(last_sum));
      check("cout_hold", 32'(COUT), 32'(last_cout));
    end
  end

  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s, input logic [W-1:0] esum, input logic ecout,
                        input string nm, input logic chk_ser, input logic [W-1:0] eser);
    int lat;
    logic [W-1:0] ser;
    lat = 0;
    ser = '0;
    @(posedge CLK); #1;
    A = a; B = b; CIN = c; START = 1'b1;
`ifdef BIT_SERIAL_ADDER_SUB_EN
    SUB = s;
`endif
    @(posedge CLK); #1;
    START = 1'b0;
    // Scramble the operands after capture; the current add must ignore them.
    A = 8'($urandom); B = 8'($urandom); CIN = 1'($urandom);
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (i <= W) ser[i-1] = SER_S;
      if (DONE) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: DONE not seen within 20 cycles", nm);
    end else begin
      check({nm, "_latency"}, 32'(lat), 32'd9);
      check({nm, "_sum"}, 32'(SUM), 32'(esum));
      check({nm, "_cout"}, 32'(COUT), 32'(ecout));
      if (chk_ser) check({nm, "_ser_seq"}, 32'(ser), 32'(eser));
    end
  endtask

  initial begin
    int dones;
    int last_done;
    int gap_bad;

    // Reset for 2 cycles, then 20 idle cycles.
    repeat (2) @(posedge CLK);
    #1 R = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    check("idle_sum", 32'(SUM), 32'h00);
    check("idle_busy", 32'(BUSY), 32'd0);

    // 0x5A + 0x3C = 0x96; the serial bits LSB-first are 0,1,1,0,1,0,0,1.
    do_add(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, "add_5a_3c", 1'b1, 8'b1001_0110);
    do_add(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "add_ff_01", 1'b0, 8'h00);
    do_add(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, "add_ff_ff_c", 1'b1, 8'hFF);

    // Hold START high: an add is accepted every W+2 = 10 cycles.
    @(posedge CLK); #1;
    A = 8'h01; B = 8'h02; CIN = 1'b0; START = 1'b1;
    dones = 0; last_done = -1; gap_bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (DONE) begin
        check("held_sum", 32'(SUM), 32'h03);
        if (last_done >= 0 && (i - last_done) != 10) gap_bad++;
        last_done = i;
        dones++;
      end
    end
    check("held_done_count", 32'(dones), 32'd3);
    check("held_done_gap", 32'(gap_bad), 32'd0);
    @(posedge CLK); #1 START = 1'b0;
    repeat (12) @(posedge CLK);

    // Apply reset in the 4th RUN cycle: the add is aborted without a DONE pulse.
    #1;
    A = 8'hAA; B = 8'h55; CIN = 1'b0; START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    repeat (3) @(posedge CLK);
    #1 R = 1'b0;
    #1;
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    check("abort_sum", 32'(SUM), 32'h00);
    check("abort_cout", 32'(COUT), 32'd0);
    check("abort_ser", 32'(SER_S), 32'd0);
    repeat (2) @(posedge CLK);
    #1 R = 1'b1;
    do_add(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, "add_after_abort", 1'b0, 8'h00);

`ifdef BIT_SERIAL_ADDER_SUB_EN
    do_add(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, "sub_10_01", 1'b0, 8'h00);
    do_add(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, "sub_01_02", 1'b0, 8'h00);
    do_add(8'h21, 8'h13, 1'b1, 1'b0, 8'h35, 1'b0, "add_sub0", 1'b0, 8'h00);
`endif

    repeat (4) @(posedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
